// File: rtl/ram_march_tester.sv
// March C- memory tester for a single-port synchronous RAM.
// Aborts on the first mismatch and reports the failing address and march element.
module ram_march_tester #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_start,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_pass,
    output logic [ADDR_W-1:0] out_fail_addr,
    output logic [2:0]        out_fail_elem,
    output logic [ADDR_W-1:0] out_ram_addr,
    output logic              out_ram_we,
    output logic [DATA_W-1:0] out_ram_wdata,
    input  logic [DATA_W-1:0] in_ram_rdata
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        elem_q, elem_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] failAddr_q, failAddr_d;
    logic [2:0]        failElem_q, failElem_d;

    logic              elemDown, nextDown, lastAddr, mismatch, ramWe;
    logic [2:0]        nextElem;
    logic [DATA_W-1:0] expWord, wrWord, ramWdata;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            elem_q     <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            failAddr_q <= '0;
            failElem_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            elem_q     <= elem_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            failAddr_q <= failAddr_d;
            failElem_q <= failElem_d;
        end
    end

    // E3/E4 walk downward; E2/E4 expect ones; E1/E3 write ones.
    always_comb begin
        elemDown = (elem_q == 3'd3) || (elem_q == 3'd4);
        nextElem = elem_q + 3'd1;
        nextDown = (nextElem == 3'd3) || (nextElem == 3'd4);
        expWord  = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
        wrWord   = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? '1 : '0;
        lastAddr = elemDown ? (addr_q == '0) : (addr_q == ADDR_MAX);
        mismatch = (in_ram_rdata != expWord);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        elem_d     = elem_q;
        done_d     = done_q;
        pass_d     = pass_q;
        failAddr_d = failAddr_q;
        failElem_d = failElem_q;
        ramWe      = 1'b0;
        ramWdata   = '0;
        case (state_q)
            IDLE, DONE: begin
                if (in_start) begin
                    state_d    = WRITE;
                    addr_d     = '0;
                    elem_d     = '0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    failAddr_d = '0;
                    failElem_d = '0;
                end
            end
            WRITE: begin
                ramWe = 1'b1;
                if (addr_q == ADDR_MAX) begin
                    state_d = READ;
                    elem_d  = 3'd1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            READ: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (mismatch) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    pass_d     = 1'b0;
                    failAddr_d = addr_q;
                    failElem_d = elem_q;
                end else begin
                    if (elem_q != 3'd5) begin
                        ramWe    = 1'b1;
                        ramWdata = wrWord;
                    end
                    if (!lastAddr) begin
                        state_d = READ;
                        addr_d  = elemDown ? addr_q - 1'b1 : addr_q + 1'b1;
                    end else if (elem_q == 3'd5) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = READ;
                        elem_d  = nextElem;
                        addr_d  = nextDown ? ADDR_MAX : '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset gates the write strobe combinationally so a reset edge never lands a write.
    assign out_ram_we    = ramWe & ~in_rst;
    assign out_ram_wdata = ramWdata;
    assign out_ram_addr  = addr_q;
    assign out_busy      = (state_q == WRITE) || (state_q == READ) || (state_q == CHECK);
    assign out_done      = done_q;
    assign out_pass      = pass_q;
    assign out_fail_addr = failAddr_q;
    assign out_fail_elem = failElem_q;

endmodule

// File: tb/tb_ram_march_tester.sv
// Bench for ram_march_tester: a faultable 16x8 RAM model plus an abstract March C-
// reference that predicts pass/fail, failing address/element and run length.
module tb_ram_march_tester;

    typedef struct {
        int kind;      // 0 none, 1 stuck-at-1, 2 stuck-at-0, 3 coupling
        int addr;
        int bitIdx;
        int aggr;
        int victim;
    } fault_t;

    typedef struct {
        fault_t f;
        bit     expPass;
        int     expAddr;
        int     expElem;
        int     expCycles;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass, ramWe;
    logic [3:0] failAddr, ramAddr;
    logic [2:0] failElem;
    logic [7:0] ramWdata, ramRdata;
    logic [7:0] ramMem [16];

    fault_t curFault = '{0, 0, 0, 0, 0};
    int     compared = 0;
    int     mismatched = 0;

    always #5 clk = ~clk;

    ram_march_tester #(.ADDR_W(4), .DATA_W(8)) dut (
        .in_clk       (clk),
        .in_rst       (rst),
        .in_start     (start),
        .out_busy     (busy),
        .out_done     (done),
        .out_pass     (pass),
        .out_fail_addr(failAddr),
        .out_fail_elem(failElem),
        .out_ram_addr (ramAddr),
        .out_ram_we   (ramWe),
        .out_ram_wdata(ramWdata),
        .in_ram_rdata (ramRdata)
    );

    function automatic logic [7:0] storedValue(input fault_t f, input int a, input logic [7:0] d);
        logic [7:0] v;
        v = d;
        if (f.kind == 1 && a == f.addr) v[f.bitIdx] = 1'b1;
        if (f.kind == 2 && a == f.addr) v[f.bitIdx] = 1'b0;
        return v;
    endfunction

    always @(posedge clk) begin
        if (ramWe) begin
            ramMem[ramAddr] <= storedValue(curFault, int'(ramAddr), ramWdata);
            if (curFault.kind == 3 && int'(ramAddr) == curFault.aggr && ramWdata == 8'hFF)
                ramMem[curFault.victim] <= ~ramMem[curFault.victim];
        end else begin
            ramRdata <= ramMem[ramAddr];
        end
    end

    // Walks the March C- element list over a plain array, charging one cycle per
    // E0 write and two per read/check; stops at the first wrong read.
    function automatic void refRun(input fault_t f, output bit rPass, output int rAddr,
                                   output int rElem, output int rCycles);
        logic [7:0] m [16];
        logic [7:0] expv, wv;
        int a;
        rPass = 1'b1; rAddr = 0; rElem = 0; rCycles = 0;
        for (int i = 0; i < 16; i++) m[i] = 8'h00;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 16; i++) begin
                a = (e == 3 || e == 4) ? 15 - i : i;
                if (e == 0) begin
                    rCycles += 1;
                end else begin
                    rCycles += 2;
                    expv = (e == 2 || e == 4) ? 8'hFF : 8'h00;
                    if (m[a] != expv) begin
                        rPass = 1'b0; rAddr = a; rElem = e;
                        return;
                    end
                end
                if (e <= 4) begin
                    wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
                    m[a] = storedValue(f, a, wv);
                    if (f.kind == 3 && a == f.aggr && wv == 8'hFF) m[f.victim] = ~m[f.victim];
                end
            end
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Pulses start, optionally re-pulses it mid-run, and counts cycles until done.
    task automatic applyStimulus(input fault_t f, input int extraStartAt, output int cycles);
        curFault = f;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busyAfterStart", int'(busy), 1);
        cycles = 0;
        while (!done && cycles < 1000) begin
            if (cycles == extraStartAt) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
        end
        checkOutput("doneWithinBudget", int'(done), 1);
    endtask

    task automatic runAndCheck(input string tag, input fault_t f, input int extraStartAt,
                               input bit expPass, input int expAddr, input int expElem,
                               input int expCycles);
        int cycles;
        applyStimulus(f, extraStartAt, cycles);
        checkOutput({tag, ".cycles"}, cycles, expCycles);
        checkOutput({tag, ".pass"}, int'(pass), int'(expPass));
        checkOutput({tag, ".busy"}, int'(busy), 0);
        if (!expPass) begin
            checkOutput({tag, ".failAddr"}, int'(failAddr), expAddr);
            checkOutput({tag, ".failElem"}, int'(failElem), expElem);
        end
    endtask

    vec_t vecs [8];

    initial begin
        fault_t noFault, rf;
        bit     mPass;
        int     mAddr, mElem, mCycles, nonZero;

        noFault = '{0, 0, 0, 0, 0};
        vecs[0] = '{'{0, 0, 0, 0, 0}, 1'b1, 0, 0, 176};
        vecs[1] = '{'{1, 5, 0, 0, 0}, 1'b0, 5, 1, 28};
        vecs[2] = '{'{2, 15, 7, 0, 0}, 1'b0, 15, 2, 80};
        vecs[3] = '{'{3, 0, 0, 3, 2}, 1'b0, 2, 2, 54};
        vecs[4] = '{'{3, 0, 0, 2, 3}, 1'b0, 3, 1, 24};
        vecs[5] = '{'{1, 0, 7, 0, 0}, 1'b0, 0, 1, 18};
        vecs[6] = '{'{2, 0, 0, 0, 0}, 1'b0, 0, 2, 50};
        vecs[7] = '{'{0, 0, 0, 0, 0}, 1'b1, 0, 0, 176};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.busy", int'(busy), 0);
        checkOutput("rst.done", int'(done), 0);
        checkOutput("rst.pass", int'(pass), 0);
        checkOutput("rst.we", int'(ramWe), 0);
        checkOutput("rst.addr", int'(ramAddr), 0);
        checkOutput("rst.wdata", int'(ramWdata), 0);
        checkOutput("rst.failAddr", int'(failAddr), 0);
        checkOutput("rst.failElem", int'(failElem), 0);

        // Reset wins over a simultaneous start
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        checkOutput("rstStart.busy", int'(busy), 0);
        @(posedge clk); #1;
        checkOutput("rstStart.busyLater", int'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].f, -1, vecs[i].expPass,
                        vecs[i].expAddr, vecs[i].expElem, vecs[i].expCycles);
            if (i == 0) begin
                nonZero = 0;
                for (int a = 0; a < 16; a++) if (ramMem[a] != 8'h00) nonZero++;
                checkOutput("ramAllZero", nonZero, 0);
            end
            if (i == 2) begin
                repeat (10) @(posedge clk);
                #1;
                checkOutput("doneHeld", int'(done), 1);
                checkOutput("failAddrHeld", int'(failAddr), 15);
                checkOutput("failElemHeld", int'(failElem), 2);
            end
        end

        // Reset in the middle of E3, then a clean restart
        curFault = noFault;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midRst.weDuringRst", int'(ramWe), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midRst.busy", int'(busy), 0);
        checkOutput("midRst.we", int'(ramWe), 0);
        checkOutput("midRst.done", int'(done), 0);
        runAndCheck("afterRst", noFault, -1, 1'b1, 0, 0, 176);

        // Start while busy is ignored
        runAndCheck("startBusy", noFault, 50, 1'b1, 0, 0, 176);

        // Random faults against the reference model
        for (int n = 0; n < 24; n++) begin
            rf.kind   = int'($urandom_range(0, 3));
            rf.addr   = int'($urandom_range(0, 15));
            rf.bitIdx = int'($urandom_range(0, 7));
            rf.aggr   = int'($urandom_range(0, 15));
            rf.victim = (rf.aggr + int'($urandom_range(1, 15))) % 16;
            refRun(rf, mPass, mAddr, mElem, mCycles);
            runAndCheck($sformatf("rnd%0d", n), rf, -1, mPass, mAddr, mElem, mCycles);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
